fft_bit_reverse_reorder: RTL and testbench

FFT_BIT_REVERSE_REORDER -- requirements
Module: fft_bit_reverse_reorder

---
 rtl/fft_pkg.sv | 32 +++
 rtl/fft_bit_reverse_reorder_ram.sv | 26 ++
 rtl/fft_bit_reverse_reorder.sv | 126 ++++++++++++
 tb/tb_fft_bit_reverse_reorder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT types and helpers: complex sample formats and a width-parameterised
// bit-reversal used to map FFT output order to natural bin order.
package fft_pkg;

  localparam int FFT_DATA_WIDTH = 16;

  typedef struct packed {
    logic signed [FFT_DATA_WIDTH-1:0] re;
    logic signed [FFT_DATA_WIDTH-1:0] im;
  } complex_t;

  typedef struct packed {
    logic signed [2*FFT_DATA_WIDTH-1:0] re;
    logic signed [2*FFT_DATA_WIDTH-1:0] im;
  } complex_product_t;

  // Reverses the low 'width' bits of value; upper result bits are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] r;
    logic [31:0] v;
    r = '0;
    v = value;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        r = {r[30:0], v[0]};
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bit_reverse_reorder_ram.sv
// Ping-pong bank storage: one write port, one registered read port.
// The address MSB selects the bank; contents are never reset.
module reorder_bank_ram
  import fft_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  complex_product_t wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output complex_product_t rd_data
);

  complex_product_t mem [DEPTH];

  // Reads and writes always target different banks, so no collision handling.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_bit_reverse_reorder.sv
// Converts bit-reversed FFT output frames into natural bin order using two
// ping-pong banks, with a registered, back-pressurable output stage.
module fft_bit_reverse_reorder
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  complex_product_t     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output complex_product_t     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_index,
  output logic                 out_last
);

  localparam int AW = $clog2(N);

  if (DATA_WIDTH != FFT_DATA_WIDTH) begin : g_bad_width
    $error("DATA_WIDTH must equal fft_pkg::FFT_DATA_WIDTH");
  end
  if ((N < 4) || ((N & (N - 1)) != 0)) begin : g_bad_size
    $error("N must be a power of two and at least 4");
  end

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and the output holds its payload until taken.

  logic [AW-1:0]    wr_cnt;
  logic [AW-1:0]    rd_cnt;
  logic             wr_bank;
  logic             rd_bank;
  logic [1:0]       full;
  logic             wr_en;
  logic             rd_en;
  logic             load_out;
  logic             wr_last;
  logic             rd_last;
  logic             s1_valid;
  logic [AW-1:0]    s1_index;
  logic [AW-1:0]    wr_idx;
  complex_product_t rd_data;

  assign in_ready = !full[wr_bank];
  assign wr_en    = in_valid && in_ready;
  assign wr_last  = (wr_cnt == AW'(N - 1));
  assign rd_last  = (rd_cnt == AW'(N - 1));
  assign wr_idx   = AW'(bitrev(32'(wr_cnt), AW));

  // s1 is the RAM read register; it advances whenever the output register does.
  assign load_out = s1_valid && (!out_valid || out_ready);
  assign rd_en    = full[rd_bank] && (!s1_valid || load_out);

  reorder_bank_ram #(
    .DEPTH (2 * N),
    .AW    (AW + 1)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr ({wr_bank, wr_idx}),
    .wr_data (in_data),
    .rd_en   (rd_en),
    .rd_addr ({rd_bank, rd_cnt}),
    .rd_data (rd_data)
  );

  // Write side and bank flags; set and clear never hit the same bank.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      if (wr_en) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_last) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= !wr_bank;
        end
      end
      if (rd_en) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (rd_last) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= !rd_bank;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_index <= '0;
    end else if (rd_en) begin
      s1_valid <= 1'b1;
      s1_index <= rd_cnt;
    end else if (load_out) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else if (load_out) begin
      out_valid <= 1'b1;
      out_data  <= rd_data;
      out_index <= s1_index;
      out_last  <= (s1_index == AW'(N - 1));
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_bit_reverse_reorder.sv
// Directed bench for the bit-reverse reorder block (N=8): single frame,
// back-to-back frames, long stall, random stalls, mid-frame reset, extremes.
module tb_fft_bit_reverse_reorder;
  import fft_pkg::*;

  localparam int N  = 8;
  localparam int AW = 3;
  localparam int EW = AW + $bits(complex_product_t);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  complex_product_t in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  complex_product_t out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [AW-1:0]    out_index;
  logic             out_last;

  fft_bit_reverse_reorder #(.DATA_WIDTH(16), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: natural bin k of a frame is the arrival at position bitrev(k).
  int               brt [N] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int               t1_seq [N] = '{0, 4, 2, 6, 1, 5, 3, 7};
  complex_product_t frame_buf [N];
  int               frame_fill = 0;
  logic [EW-1:0]    exp_q [$];
  logic [EW-1:0]    stall_val;
  logic             stall_prev = 1'b0;
  int               test_id = 0;
  int               n_out = 0;
  int               first_out_edge = -1;
  int               last_out_edge = 0;
  int               last_accept_edge = 0;
  int               ready_low_cnt = 0;
  complex_product_t stim [64];

  always @(negedge clk) begin
    if (!reset) begin
      frame_fill = 0;
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        frame_buf[frame_fill] = in_data;
        frame_fill++;
        last_accept_edge = cyc + 1;
        if (frame_fill == N) begin
          for (int k = 0; k < N; k++) exp_q.push_back({AW'(k), frame_buf[brt[k]]});
          frame_fill = 0;
        end
      end
      if (in_valid && !in_ready) ready_low_cnt++;
      if (stall_prev) begin
        check("stall_valid", EW'(out_valid), EW'(1));
        check("stall_hold", {out_index, out_data}, stall_val);
      end
      if (out_valid) begin
        if (first_out_edge < 0) first_out_edge = cyc;
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_out", EW'(out_valid), EW'(0));
          end else begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            check("out_sample", {out_index, out_data}, e);
            check("out_last", EW'(out_last), EW'(e[EW-1 -: AW] == AW'(N - 1)));
          end
          if (test_id == 1 && n_out < N) check("t1_order", EW'(out_data.re), EW'(t1_seq[n_out]));
          n_out++;
          last_out_edge = cyc;
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_val  = {out_index, out_data};
    end
  end

  task automatic fill_stim(input int mode, input int base);
    for (int i = 0; i < 64; i++) begin
      if (mode == 0) begin
        stim[i].re = 32'(base + i);
        stim[i].im = 32'(1000 + base + i);
      end else begin
        stim[i].re = (i % 2 == 0) ? 32'h7FFFFFFF : 32'h80000000;
        stim[i].im = (i % 3 == 0) ? 32'h80000000 : 32'h7FFFFFFF;
      end
    end
  endtask

  task automatic run_stream(input int n, input int stall_cyc, input bit rand_ready);
    int idx = 0;
    int t = 0;
    while (idx < n && t < 2000) begin
      @(posedge clk); #1;
      out_ready = (t < stall_cyc) ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      in_valid  = 1'b1;
      in_data   = stim[idx];
      @(negedge clk);
      if (t < stall_cyc && idx >= 2 * N) check("bp_in_ready", EW'(in_ready), EW'(0));
      if (in_ready) idx++;
      if (stall_cyc > 0 && t == stall_cyc - 1) check("stall_accepts", EW'(idx), EW'(2 * N));
      t++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (idx < n) check("input_timeout", EW'(idx), EW'(n));
  endtask

  task automatic drain();
    int t = 0;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", EW'(exp_q.size()), EW'(0));
  endtask

  task automatic start_test(input int id);
    test_id        = id;
    n_out          = 0;
    first_out_edge = -1;
    ready_low_cnt  = 0;
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", EW'(in_ready), EW'(1));
    check("rst_out_valid", EW'(out_valid), EW'(0));
    check("rst_out_last", EW'(out_last), EW'(0));
    check("rst_out_index", EW'(out_index), EW'(0));
    check("rst_out_data", EW'(out_data), EW'(0));
    @(posedge clk); #1;
    reset = 1'b1;

    // Single frame, natural-order output and first-output latency.
    start_test(1);
    fill_stim(0, 0);
    run_stream(N, 0, 1'b0);
    drain();
    check("t1_count", EW'(n_out), EW'(N));
    check("t1_latency", EW'(first_out_edge - last_accept_edge), EW'(2));

    // Four back-to-back frames at full rate.
    start_test(2);
    fill_stim(0, 100);
    run_stream(4 * N, 0, 1'b0);
    drain();
    check("t2_count", EW'(n_out), EW'(4 * N));
    check("t2_no_gap", EW'(last_out_edge - first_out_edge), EW'(4 * N - 1));
    check("t2_ready_drops", EW'(ready_low_cnt), EW'(0));

    // Output stalled for 20 cycles while three frames are offered.
    start_test(3);
    fill_stim(0, 200);
    run_stream(3 * N, 20, 1'b0);
    drain();
    check("t3_count", EW'(n_out), EW'(3 * N));

    // Random 50% downstream back-pressure.
    start_test(4);
    fill_stim(0, 300);
    run_stream(3 * N, 0, 1'b1);
    drain();
    check("t4_count", EW'(n_out), EW'(3 * N));

    // Reset after a partial frame; only the new frame may come out.
    start_test(5);
    fill_stim(0, 400);
    run_stream(5, 0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t5_rst_valid", EW'(out_valid), EW'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("t5_in_ready", EW'(in_ready), EW'(1));
    fill_stim(0, 500);
    run_stream(N, 0, 1'b0);
    drain();
    check("t5_count", EW'(n_out), EW'(N));

    // Extreme component values must pass bit-exact.
    start_test(6);
    fill_stim(1, 0);
    run_stream(2 * N, 0, 1'b0);
    drain();
    check("t6_count", EW'(n_out), EW'(2 * N));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
